direct_mapped_cache: RTL and testbench
======================================

Name: direct_mapped_cache

Overview:
Direct-mapped, write-through, no-write-allocate cache that responds to the cache controller's cache_read/cache_write/address requests. It returns data with a one-cycle cache_ready pulse. Misses are refilled as whole blocks from main memory. It keeps the running read-hit counter that the controller uses to compute hit rate.

Parameters:
ADDR_W, 15, word address width; tag width = ADDR_W-INDEX_W-OFFSET_W (3 by default)
INDEX_W, 10, line index width; the cache has 2**INDEX_W lines
OFFSET_W, 2, word-in-block width; each block holds 2**OFFSET_W words
DATA_W, 32, word width; one block = DATA_W*2**OFFSET_W bits (128 by default)

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
cache_read  in  1  read request; held by the controller until it sees cache_ready
cache_write  in  1  write request; read wins if both are high
address  in  ADDR_W  word address; must stay stable while a request is pending
wdata  in  DATA_W  write data
cache_ready  out  1  one-cycle done pulse for the current request
rdata  out  DATA_W  read data; valid while cache_ready=1
hit_count  out  14  count of read hits
mem_read  out  1  block read request to main memory
mem_write  out  1  word write request to main memory
mem_address  out  ADDR_W  memory address; offset bits forced to 0 for block reads
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W*2**OFFSET_W  refill block; word k sits at bits [k*DATA_W +: DATA_W]
mem_ready  in  1  memory done; rdata is valid in the same cycle

Behaviour:
- Address split: tag=address[ADDR_W-1:INDEX_W+OFFSET_W], index=address[INDEX_W+OFFSET_W-1:OFFSET_W], offset=address[OFFSET_W-1:0].
- Storage per line: valid bit, tag, data block. Valid bits are flops, cleared by rst in one cycle. Data and tag arrays are not reset.
- Reset (at any time, including mid-refill): state=IDLE; cache_ready, mem_read, mem_write = 0; hit_count=0; rdata=0; mem_address=0; mem_wdata=0; all valid bits = 0.
- IDLE: if cache_read, latch address and op=READ, go to COMPARE. Else if cache_write, latch address, wdata and op=WRITE, go to COMPARE. Else stay.
- COMPARE (one cycle): hit = valid[index] && tag match.
  - READ hit: go to RESP; hit_count += 1, saturating at 16383.
  - READ miss: go to MEM_RD; drive mem_read=1 and mem_address={tag,index,0}.
  - WRITE: if hit, update the word at offset in the line. Either way go to MEM_WR; drive mem_write=1, mem_address=latched address, mem_wdata=latched wdata.
- MEM_RD: hold mem_read and mem_address until mem_ready=1. On that edge: write mem_rdata into the data array, set the tag, set valid=1, drop mem_read, go to RESP. A miss does not increment hit_count.
- MEM_WR: hold mem_write until mem_ready=1, then drop it and go to RESP.
- RESP (exactly one cycle): cache_ready=1. For READ, rdata = word[offset] of the line. Then go to IDLE.
- Latency: read hit = cache_ready in the 2nd cycle after IDLE samples the request. Read miss = mem_ready cycle + 1.
- No double service: the controller advances address on the RESP edge. The block is in IDLE the following cycle and samples the new address.
- Conflict: a refill unconditionally overwrites the line at that index (no dirty data exists).
- Writes never count toward hit_count.

Test Plan:
- Cold read: after rst, read address=1024, mem_ready returned 3 cycles after mem_read -> mem_address=1024, mem_read high 3 cycles, cache_ready 1 cycle with rdata=word0 of the block, hit_count=0.
- Read hit: next read address=1025 after the above refill -> no mem_read, cache_ready in the 2nd cycle after request, rdata=word1, hit_count=1.
- Controller sweep: 8192 sequential reads from address 1024, memory returns data 1 cycle after each mem_read -> 2048 refills, final hit_count=6144, exactly 8192 cache_ready pulses.
- Conflict: read 0, then 4096 (same index 0, tags 0/1), then 0 -> three misses, hit_count=0, last rdata equals memory word 0.
- Write-through: read 8 (miss), write address 9 with wdata=0xDEADBEEF -> mem_write with mem_address=9 and mem_wdata=0xDEADBEEF; a later read of 9 hits with rdata=0xDEADBEEF. A write to uncached address 200 -> mem_write only, a later read of 200 misses.
- Reset mid-refill: assert rst while mem_read=1 -> next cycle mem_read=0, hit_count=0. A subsequent read of the same address misses.

Source files
------------

// File: rtl/direct_mapped_cache.sv
// Direct-mapped write-through, no-write-allocate cache with whole-block refill.
// Read hit answers two cycles after the request is sampled; misses and writes wait on mem_ready.
module direct_mapped_cache #(
  parameter int ADDR_W   = 15,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 2,
  parameter int DATA_W   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cache_read,
  input  logic                           cache_write,
  input  logic [ADDR_W-1:0]              address,
  input  logic [DATA_W-1:0]              wdata,
  output logic                           cache_ready,
  output logic [DATA_W-1:0]              rdata,
  output logic [13:0]                    hit_count,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [ADDR_W-1:0]              mem_address,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W*(2**OFFSET_W)-1:0] mem_rdata,
  input  logic                           mem_ready
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 2**INDEX_W;
  localparam int WORDS = 2**OFFSET_W;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    MEM_RD,
    MEM_WR,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                op_read;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;

  logic [LINES-1:0]                   valid;
  logic [TAG_W-1:0]                   tag_mem  [LINES];
  logic [WORDS-1:0][DATA_W-1:0]       data_mem [LINES];

  logic [TAG_W-1:0]              req_tag;
  logic [INDEX_W-1:0]            req_index;
  logic [OFFSET_W-1:0]           req_offset;
  logic                          hit;
  logic [WORDS-1:0][DATA_W-1:0]  line_blk;
  logic [WORDS-1:0][DATA_W-1:0]  refill_blk;
  logic                          refill;
  logic                          write_hit;

  assign req_tag    = req_addr[ADDR_W-1:INDEX_W+OFFSET_W];
  assign req_index  = req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign req_offset = req_addr[OFFSET_W-1:0];
  assign hit        = valid[req_index] && (tag_mem[req_index] == req_tag);
  assign line_blk   = data_mem[req_index];
  assign refill_blk = mem_rdata;
  assign refill     = (state == MEM_RD) && mem_ready;
  assign write_hit  = (state == COMPARE) && !op_read && hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cache_read || cache_write) state_nxt = COMPARE;
      COMPARE: begin
        if (!op_read)  state_nxt = MEM_WR;
        else if (hit)  state_nxt = RESP;
        else           state_nxt = MEM_RD;
      end
      MEM_RD:  if (mem_ready) state_nxt = RESP;
      MEM_WR:  if (mem_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered images of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_ready <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
      hit_count   <= '0;
      op_read     <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
    end else begin
      cache_ready <= (state_nxt == RESP);
      mem_read    <= (state_nxt == MEM_RD);
      mem_write   <= (state_nxt == MEM_WR);
      case (state)
        IDLE: begin
          if (cache_read) begin
            op_read  <= 1'b1;
            req_addr <= address;
          end else if (cache_write) begin
            op_read   <= 1'b0;
            req_addr  <= address;
            req_wdata <= wdata;
          end
        end
        COMPARE: begin
          if (op_read) begin
            if (hit) begin
              rdata <= line_blk[req_offset];
              if (hit_count != {14{1'b1}}) hit_count <= hit_count + 14'd1;
            end else begin
              mem_address <= {req_tag, req_index, {OFFSET_W{1'b0}}};
            end
          end else begin
            mem_address <= req_addr;
            mem_wdata   <= req_wdata;
          end
        end
        MEM_RD: begin
          if (mem_ready) rdata <= refill_blk[req_offset];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (refill) begin
      valid[req_index] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (refill) begin
      data_mem[req_index] <= refill_blk;
      tag_mem[req_index]  <= req_tag;
    end else if (write_hit) begin
      data_mem[req_index][req_offset] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_direct_mapped_cache.sv
module tb_direct_mapped_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic         cache_read;
  logic         cache_write;
  logic [14:0]  address;
  logic [31:0]  wdata;
  logic         cache_ready;
  logic [31:0]  rdata;
  logic [13:0]  hit_count;
  logic         mem_read;
  logic         mem_write;
  logic [14:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  always #5 clk = ~clk;

  direct_mapped_cache dut (
    .clk(clk), .rst(rst),
    .cache_read(cache_read), .cache_write(cache_write),
    .address(address), .wdata(wdata),
    .cache_ready(cache_ready), .rdata(rdata), .hit_count(hit_count),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  // Abstract model: memory contents plus which tag each line holds.
  logic [31:0] mem_model [int];
  bit          mvalid [1024];
  logic [2:0]  mtag   [1024];
  int          exp_hits = 0;
  bit          exp_read = 1'b1;
  bit          exp_hit  = 1'b0;
  logic [14:0] exp_addr = '0;
  logic [31:0] exp_data = '0;
  int          mem_lat  = 1;
  int          wait_cnt = 0;
  int          refills  = 0;
  int          pulses   = 0;
  bit          prev_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mword(input logic [14:0] a);
    if (mem_model.exists(int'(a))) return mem_model[int'(a)];
    return 32'hA5000000 | 32'(a);
  endfunction

  // Main memory: answers after mem_lat cycles of a pending request.
  always @(negedge clk) begin
    if (rst) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
    end else if (mem_read || mem_write) begin
      wait_cnt++;
      if (wait_cnt >= mem_lat) begin
        wait_cnt  = 0;
        mem_ready = 1'b1;
        if (mem_read) begin
          for (int k = 0; k < 4; k++)
            mem_rdata[k*32 +: 32] = mword({mem_address[14:2], 2'(k)});
          refills++;
        end else begin
          mem_model[int'(mem_address)] = mem_wdata;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_ready) chk("ready_width", {31'b0, cache_ready}, 32'd0);
      if (cache_ready) begin
        pulses++;
        if (exp_read) chk("rdata", rdata, exp_data);
        chk("hit_count", {18'b0, hit_count}, exp_hits);
      end
      if (exp_read && exp_hit) chk("no_mem_read_on_hit", {31'b0, mem_read}, 32'd0);
      if (exp_read) chk("no_mem_write_on_read", {31'b0, mem_write}, 32'd0);
      if (mem_read) chk("mem_rd_addr", {17'b0, mem_address}, {17'b0, exp_addr[14:2], 2'b00});
      if (mem_write) begin
        chk("mem_wr_addr", {17'b0, mem_address}, {17'b0, exp_addr});
        chk("mem_wdata", mem_wdata, exp_data);
      end
      prev_ready = cache_ready;
    end else begin
      prev_ready = 1'b0;
    end
  end

  task automatic req(input bit is_rd, input logic [14:0] a, input logic [31:0] d, input int lat);
    logic [9:0] idx;
    logic [2:0] tg;
    int cyc;
    bit got;
    idx = a[11:2];
    tg  = a[14:12];
    @(posedge clk); #1;
    exp_read = is_rd;
    exp_addr = a;
    mem_lat  = lat;
    if (is_rd) begin
      exp_hit  = mvalid[idx] && (mtag[idx] == tg);
      exp_data = mword(a);
      if (exp_hit) begin
        if (exp_hits < 16383) exp_hits++;
      end else begin
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
      end
    end else begin
      exp_hit  = 1'b0;
      exp_data = d;
    end
    cache_read  = is_rd;
    cache_write = !is_rd;
    address     = a;
    wdata       = d;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cache_ready) got = 1'b1;
    end
    if (!got) chk("ready_seen", {31'b0, cache_ready}, 32'd1);
    else chk("latency", cyc, (is_rd && exp_hit) ? 3 : 3 + lat);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    cache_read  = 1'b0;
    cache_write = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cache_read  = 1'b0;
    cache_write = 1'b0;
    @(posedge clk); #1;
    chk("rst_cache_ready", {31'b0, cache_ready}, 32'd0);
    chk("rst_mem_read",    {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write",   {31'b0, mem_write}, 32'd0);
    chk("rst_hit_count",   {18'b0, hit_count}, 32'd0);
    chk("rst_rdata",       rdata, 32'd0);
    chk("rst_mem_address", {17'b0, mem_address}, 32'd0);
    chk("rst_mem_wdata",   mem_wdata, 32'd0);
    for (int i = 0; i < 1024; i++) mvalid[i] = 1'b0;
    exp_hits = 0;
    exp_hit  = 1'b0;
    exp_read = 1'b1;
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    cache_read = 1'b0;
    cache_write = 1'b0;
    address = '0;
    wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    do_reset();

    // Cold miss then hit in the same block.
    req(1'b1, 15'd1024, 32'd0, 3);
    chk("cold_rdata_lit", rdata, 32'hA5000400);
    chk("cold_hits_lit", {18'b0, hit_count}, 32'd0);
    req(1'b1, 15'd1025, 32'd0, 1);
    chk("hit_rdata_lit", rdata, 32'hA5000401);
    chk("hit_hits_lit", {18'b0, hit_count}, 32'd1);
    idle();

    // Sequential sweep, back-to-back requests.
    do_reset();
    pulses  = 0;
    refills = 0;
    for (int i = 0; i < 8192; i++) req(1'b1, 15'(1024 + i), 32'd0, 1);
    idle();
    chk("sweep_hits_lit", {18'b0, hit_count}, 32'd6144);
    chk("sweep_refills_lit", refills, 32'd2048);
    chk("sweep_pulses_lit", pulses, 32'd8192);

    // Drive hit_count into saturation.
    for (int i = 0; i < 10242; i++) req(1'b1, 15'd5121, 32'd0, 1);
    idle();
    chk("sat_hits_lit", {18'b0, hit_count}, 32'd16383);

    // Conflict on index 0.
    do_reset();
    req(1'b1, 15'd0, 32'd0, 2);
    req(1'b1, 15'd4096, 32'd0, 2);
    req(1'b1, 15'd0, 32'd0, 2);
    chk("conflict_rdata_lit", rdata, 32'hA5000000);
    chk("conflict_hits_lit", {18'b0, hit_count}, 32'd0);
    idle();

    // Write-through, write hit updates line, write miss does not allocate.
    req(1'b1, 15'd8, 32'd0, 2);
    req(1'b0, 15'd9, 32'hDEADBEEF, 2);
    req(1'b1, 15'd9, 32'd0, 1);
    chk("wt_hit_rdata_lit", rdata, 32'hDEADBEEF);
    req(1'b0, 15'd200, 32'h12345678, 3);
    req(1'b1, 15'd200, 32'd0, 2);
    chk("wt_miss_rdata_lit", rdata, 32'h12345678);
    idle();

    // Reset while a refill is outstanding.
    @(posedge clk); #1;
    exp_read = 1'b1;
    exp_hit  = 1'b0;
    exp_addr = 15'd300;
    exp_data = mword(15'd300);
    mem_lat  = 20;
    cache_read = 1'b1;
    address    = 15'd300;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_read) seen = 1'b1;
    end
    chk("midrefill_mem_read", {31'b0, mem_read}, 32'd1);
    do_reset();
    req(1'b1, 15'd300, 32'd0, 2);
    chk("after_rst_hits_lit", {18'b0, hit_count}, 32'd0);
    idle();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
